// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared types and constants for the spi bus arbiter
package spi_ctrl_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_TIMEOUT    = 1024;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        GAP
    } spi_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational round-robin picker
// Returns the first asserted request at or after ptr, wrapping around.
module spi_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] cand;

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= N) ? s - N : s;
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'(wrap_idx(int'(ptr), k));
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin sharing of one spi_master between byte-stream requesters
// Each grant covers a whole burst; bytes are sequenced LOAD/START/WAIT_DONE/GAP with a done watchdog.
module spi_bus_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      timeout_err,
    output logic                      m_start,
    output logic [BYTE_W-1:0]         m_data,
    input  logic                      m_done
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);

    spi_state_t state, state_nx;

    logic [PW-1:0]      ptr_q, g_idx_q, pick_idx;
    logic [NUM_REQ-1:0] pick_grant, grant_q, ready_q;
    logic               pick_any;
    logic               last_q;
    logic [TW-1:0]      to_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [BYTE_W-1:0]  m_data_q;

    logic              cur_valid, cur_last, to_evt, gap_done;
    logic [BYTE_W-1:0] cur_data;

    spi_rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g_idx_q == PW'(i)) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_data  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign to_evt   = (state == WAIT_DONE) && !m_done && (to_cnt == TO_LAST);
    assign gap_done = ({1'b0, gap_cnt} + (GW+1)'(1)) >= {1'b0, GAP_MAX};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A done level still high at the end of GAP holds the FSM so it cannot retrigger.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (pick_any) state_nx = LOAD;
            LOAD:      if (cur_valid) state_nx = START;
            START:     state_nx = WAIT_DONE;
            WAIT_DONE: if (m_done || to_evt) state_nx = GAP;
            GAP:       if (gap_done && !m_done) state_nx = (grant_q == '0) ? IDLE : LOAD;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        m_start     = (state == START);
        timeout_err = to_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            g_idx_q  <= '0;
            grant_q  <= '0;
            ready_q  <= '0;
            last_q   <= 1'b0;
            to_cnt   <= '0;
            gap_cnt  <= '0;
            m_data_q <= '0;
        end else begin
            ready_q <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_grant;
                        g_idx_q <= pick_idx;
                    end
                end
                LOAD: begin
                    if (cur_valid) begin
                        m_data_q <= cur_data;
                        last_q   <= cur_last;
                    end
                end
                START: to_cnt <= '0;
                WAIT_DONE: begin
                    if (m_done || to_evt) begin
                        gap_cnt <= '0;
                        if (m_done) ready_q <= grant_q;
                        // An empty grant tells GAP the burst has ended.
                        if (to_evt || last_q) begin
                            grant_q <= '0;
                            ptr_q   <= PW'(rr_next(int'(g_idx_q), NUM_REQ));
                        end
                    end else if (to_cnt != TO_LAST) begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + GW'(1);
                end
                default: ;
            endcase
        end
    end

    assign grant     = grant_q;
    assign req_ready = ready_q;
    assign m_data    = m_data_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - scoreboard bench for spi_bus_arbiter
module tb_spi_bus_arbiter;

    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int TO  = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           busy, timeout_err, m_start, m_done;
    logic [7:0]     m_data;

    spi_bus_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
        .timeout_err(timeout_err), .m_start(m_start), .m_data(m_data), .m_done(m_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] d; logic l; } byte_t;
    typedef struct { logic [N-1:0] g; logic [7:0] d; } st_t;
    typedef struct { logic [N-1:0] r; logic t; } cp_t;

    byte_t rq [N][$];
    st_t   exp_st[$];
    cp_t   exp_cp[$];
    st_t   es;
    cp_t   ec;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requester model: pops its head byte on req_ready, then presents the next.
    initial begin
        req_valid = '0; req_data = '0; req_last = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = rq[i][0].d;
                    req_last[i]        = rq[i][0].l;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // SPI master model: done rises dly cycles after start, held for dlen cycles.
    int dly = 2, dlen = 1, hang_cnt = 0;
    initial begin
        m_done = 1'b0;
        forever begin
            @(negedge clk);
            if (m_start && !reset) begin
                if (hang_cnt > 0) hang_cnt--;
                else begin
                    repeat (dly) @(posedge clk);
                    #1 m_done = 1'b1;
                    repeat (dlen) @(posedge clk);
                    #1 m_done = 1'b0;
                end
            end
        end
    end

    int start_cyc = 0, rise_cyc = 0, high_cyc = 0, drops = 0;
    bit have_done = 0;
    logic prev_done = 1'b0;
    logic [N-1:0] prev_grant = '0, hold_g = '0;

    always @(negedge clk) begin
        if (reset) begin
            have_done  = 0;
            prev_done  = 1'b0;
            prev_grant = '0;
        end else begin
            if (m_done && !prev_done && busy) begin
                rise_cyc  = cyc;
                have_done = 1;
            end
            if (m_done) high_cyc = cyc;
            if (m_start) begin
                if (exp_st.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    es = exp_st.pop_front();
                    chk("start_grant", 32'(grant), 32'(es.g));
                    chk("start_data", 32'(m_data), 32'(es.d));
                end
                if (have_done) begin
                    chk("gap_after_done_rise", 32'(cyc - rise_cyc >= GAP + 2), 1);
                    chk("gap_after_done_fall", 32'(cyc - high_cyc >= 3), 1);
                end
                start_cyc = cyc;
            end
            if (req_ready != '0 || timeout_err) begin
                if (exp_cp.size() == 0) chk("cpl_unexpected", 1, 0);
                else begin
                    ec = exp_cp.pop_front();
                    chk("cpl_ready", 32'(req_ready), 32'(ec.r));
                    chk("cpl_timeout", 32'(timeout_err), 32'(ec.t));
                end
                if (timeout_err) begin
                    chk("timeout_latency", cyc - start_cyc, TO);
                    have_done = 0;
                end else begin
                    chk("ready_latency", cyc - rise_cyc, 1);
                end
            end
            if (hold_g != '0 && grant != '0) chk("grant_held", 32'(grant), 32'(hold_g));
            if (prev_grant != '0 && grant == '0) drops++;
            prev_done  = m_done;
            prev_grant = grant;
        end
    end

    function automatic bit rq_pending();
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1;
        return 0;
    endfunction

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy || exp_st.size() != 0 || exp_cp.size() != 0 || rq_pending()) && k < 400) begin
            @(posedge clk); #2;
            k++;
        end
        chk(name, 32'(k < 400), 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_st.delete();
        exp_cp.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back('{d: d, l: l});
    endtask

    task automatic expect_byte(input int r, input logic [7:0] d);
        exp_st.push_back('{g: N'(1 << r), d: d});
        exp_cp.push_back('{r: N'(1 << r), t: 1'b0});
    endtask

    int k;

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_m_start", 32'(m_start), 0);
        chk("rst_m_data", 32'(m_data), 0);
        @(posedge clk); #1 reset = 1'b0;

        // single byte with latency checks
        @(negedge clk);
        expect_byte(0, 8'hA5);
        push(0, 8'hA5, 1'b1);
        @(negedge clk);
        chk("single_grant_N", 32'(grant), 0);
        @(negedge clk);
        chk("single_grant_N1", 32'(grant), 32'h1);
        chk("single_start_N1", 32'(m_start), 0);
        @(negedge clk);
        chk("single_start_N2", 32'(m_start), 1);
        wait_idle("single_drain");
        chk("single_busy_end", 32'(busy), 0);

        // three-byte burst on requester 2
        @(negedge clk);
        drops  = 0;
        hold_g = 4'b0100;
        expect_byte(2, 8'h11); expect_byte(2, 8'h22); expect_byte(2, 8'h33);
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        wait_idle("burst_drain");
        chk("burst_grant_drops", drops, 1);
        hold_g = '0;

        // pointer is 3 here: 0 wins first, then alternation
        @(negedge clk);
        expect_byte(0, 8'h01); expect_byte(1, 8'h11); expect_byte(0, 8'h02); expect_byte(1, 8'h12);
        push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b1);
        push(1, 8'h11, 1'b1); push(1, 8'h12, 1'b1);
        wait_idle("rr_alt_drain");

        // three requesters from pointer 0: order 0,1,3,0
        do_reset();
        @(negedge clk);
        expect_byte(0, 8'h0A); expect_byte(1, 8'h1A); expect_byte(3, 8'h3A); expect_byte(0, 8'h0B);
        push(0, 8'h0A, 1'b1); push(0, 8'h0B, 1'b1);
        push(1, 8'h1A, 1'b1); push(3, 8'h3A, 1'b1);
        wait_idle("rr_three_drain");

        // watchdog: first byte hangs, requester 2 served next, requester 1 retried
        do_reset();
        @(negedge clk);
        hang_cnt = 1;
        exp_st.push_back('{g: 4'b0010, d: 8'h5C});
        exp_cp.push_back('{r: 4'b0000, t: 1'b1});
        expect_byte(2, 8'h6D);
        expect_byte(1, 8'h5C);
        push(1, 8'h5C, 1'b1); push(2, 8'h6D, 1'b1);
        wait_idle("timeout_drain");

        // sticky done level on a two-byte burst
        @(negedge clk);
        dlen = 10;
        expect_byte(3, 8'h77); expect_byte(3, 8'h88);
        push(3, 8'h77, 1'b0); push(3, 8'h88, 1'b1);
        wait_idle("sticky_drain");
        dlen = 1;

        // move the pointer off 0, then reset in WAIT_DONE
        @(negedge clk);
        expect_byte(0, 8'hC0);
        push(0, 8'hC0, 1'b1);
        wait_idle("pre_reset_drain");
        @(negedge clk);
        hang_cnt = 1;
        exp_st.push_back('{g: 4'b0100, d: 8'h99});
        push(2, 8'h99, 1'b1);
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (m_start) break;
            k++;
        end
        chk("mid_rst_start_seen", 32'(k < 50), 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        exp_st.delete();
        exp_cp.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_m_start", 32'(m_start), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        expect_byte(0, 8'hB0); expect_byte(1, 8'hB1);
        push(1, 8'hB1, 1'b1); push(0, 8'hB0, 1'b1);
        wait_idle("post_reset_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
